// File: rtl/semaforo_controlador.sv
// Two-way crossing phase sequencer: NS and LO approaches with min/max green,
// fixed yellow and all-red clearance. All lamp outputs are registered.
module semaforo_controlador #(
    parameter int T_MIN_GREEN = 8,
    parameter int T_MAX_GREEN = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       ns_green,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       lo_green,
    output logic       lo_yellow,
    output logic       lo_red,
    output logic [2:0] fase,
    output logic       troca
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_LO = 3'd2,
        LO_GREEN  = 3'd3,
        LO_YELLOW = 3'd4,
        RED_TO_NS = 3'd5
    } fase_t;

    localparam logic [CNT_W-1:0] MIN_END = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_END = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_END = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] RED_END = CNT_W'(T_ALL_RED - 1);

    fase_t            state;
    fase_t            state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             dem_ns;
    logic             dem_lo;
    logic             ns_go;
    logic             lo_go;
    logic             in_green;

    assign dem_ns = A | B;
    assign dem_lo = C | D;

    // A green yields only to a waiting side, and is forced at the max point.
    assign ns_go = (cnt >= MIN_END) && dem_lo && (!dem_ns || cnt == MAX_END);
    assign lo_go = (cnt >= MIN_END) && dem_ns && (!dem_lo || cnt == MAX_END);

    assign in_green = (state == NS_GREEN) || (state == LO_GREEN);

    always_comb begin
        state_nx = state;
        case (state)
            NS_GREEN:  if (ns_go) state_nx = NS_YELLOW;
            NS_YELLOW: if (cnt == YEL_END) state_nx = RED_TO_LO;
            RED_TO_LO: if (cnt == RED_END) state_nx = LO_GREEN;
            LO_GREEN:  if (lo_go) state_nx = LO_YELLOW;
            LO_YELLOW: if (cnt == YEL_END) state_nx = RED_TO_NS;
            RED_TO_NS: if (cnt == RED_END) state_nx = NS_GREEN;
            default:   state_nx = RED_TO_NS;
        endcase
    end

    always_comb begin
        cnt_nx = cnt + CNT_W'(1);
        if (state_nx != state) begin
            cnt_nx = '0;
        end else if (in_green && cnt == MAX_END) begin
            cnt_nx = cnt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RED_TO_NS;
            cnt       <= '0;
            ns_green  <= 1'b0;
            ns_yellow <= 1'b0;
            ns_red    <= 1'b1;
            lo_green  <= 1'b0;
            lo_yellow <= 1'b0;
            lo_red    <= 1'b1;
            troca     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ns_green  <= (state_nx == NS_GREEN);
            ns_yellow <= (state_nx == NS_YELLOW);
            ns_red    <= !(state_nx == NS_GREEN || state_nx == NS_YELLOW);
            lo_green  <= (state_nx == LO_GREEN);
            lo_yellow <= (state_nx == LO_YELLOW);
            lo_red    <= !(state_nx == LO_GREEN || state_nx == LO_YELLOW);
            troca     <= (state_nx != state) &&
                         (state_nx == NS_GREEN || state_nx == LO_GREEN);
        end
    end

    assign fase = state;

endmodule

// File: tb/tb_semaforo_controlador.sv
// Bench for semaforo_controlador: phase-level model checked every cycle,
// plus directed scenarios with hand-computed phase lengths.
module tb_semaforo_controlador;

    localparam int T_MIN = 8;
    localparam int T_MAX = 20;
    localparam int T_YEL = 3;
    localparam int T_RED = 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       C = 1'b0;
    logic       D = 1'b0;
    logic       ns_green;
    logic       ns_yellow;
    logic       ns_red;
    logic       lo_green;
    logic       lo_yellow;
    logic       lo_red;
    logic [2:0] fase;
    logic       troca;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    int m_ph = 5;
    int m_age = 0;
    bit m_troca = 1'b0;

    semaforo_controlador #(
        .T_MIN_GREEN(T_MIN),
        .T_MAX_GREEN(T_MAX),
        .T_YELLOW   (T_YEL),
        .T_ALL_RED  (T_RED),
        .CNT_W      (8)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .ns_green (ns_green),
        .ns_yellow(ns_yellow),
        .ns_red   (ns_red),
        .lo_green (lo_green),
        .lo_yellow(lo_yellow),
        .lo_red   (lo_red),
        .fase     (fase),
        .troca    (troca)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Phase model: phase index cycles 0..5, age = cycles already shown.
    always @(negedge reset_n) begin
        m_ph = 5;
        m_age = 0;
        m_troca = 1'b0;
    end

    always @(posedge clock) begin
        if (reset_n) begin
            bit dns;
            bit dlo;
            bit leave;
            int shown;
            dns = A | B;
            dlo = C | D;
            shown = m_age + 1;
            leave = 1'b0;
            if (m_ph == 0)
                leave = shown >= T_MIN && dlo && (!dns || shown >= T_MAX);
            else if (m_ph == 3)
                leave = shown >= T_MIN && dns && (!dlo || shown >= T_MAX);
            else if (m_ph == 1 || m_ph == 4)
                leave = shown == T_YEL;
            else
                leave = shown == T_RED;
            if (leave) begin
                m_ph = (m_ph + 1) % 6;
                m_age = 0;
                m_troca = (m_ph == 0 || m_ph == 3);
            end else begin
                m_age++;
                m_troca = 1'b0;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            logic [9:0] exp_v;
            logic [9:0] act_v;
            exp_v = {m_ph == 0, m_ph == 1, !(m_ph == 0 || m_ph == 1),
                     m_ph == 3, m_ph == 4, !(m_ph == 3 || m_ph == 4),
                     3'(m_ph), m_troca};
            act_v = {ns_green, ns_yellow, ns_red,
                     lo_green, lo_yellow, lo_red, fase, troca};
            chk("model", int'(act_v), int'(exp_v));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic lamp(input int k);
        case (k)
            0: return ns_green;
            1: return ns_yellow;
            2: return ns_red && lo_red;
            3: return lo_green;
            4: return lo_yellow;
            default: return 1'b0;
        endcase
    endfunction

    task automatic len(input int k, output int n);
        n = 0;
        while (lamp(k) && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {A, B, C, D} = 4'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int g;
        reset_n = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_fase", int'(fase), 5);
        chk("rst_reds", int'({ns_red, lo_red}), 3);
        chk("rst_rest", int'({ns_green, ns_yellow, lo_green, lo_yellow, troca}), 0);

        reset_n = 1'b1;
        tick();
        chk("t1_green", int'(ns_green), 1);
        chk("t1_troca", int'(troca), 1);
        g = 0;
        repeat (100) begin
            g += int'(ns_green);
            tick();
        end
        chk("t1_hold", g, 100);

        do_reset();
        C = 1'b1;
        len(0, n); chk("t2_ns_green", n, 8);
        len(1, n); chk("t2_ns_yellow", n, 3);
        len(2, n); chk("t2_all_red", n, 1);
        chk("t2_lo_green", int'(lo_green), 1);
        chk("t2_troca", int'(troca), 1);

        A = 1'b1;
        len(3, n); chk("t3_lo_green", n, 20);
        len(4, n); chk("t3_lo_yellow", n, 3);
        len(2, n); chk("t3_red_ns", n, 1);
        len(0, n); chk("t3_ns_green", n, 20);
        len(1, n); chk("t3_ns_yellow", n, 3);
        len(2, n); chk("t3_red_lo", n, 1);
        chk("t3_again", int'(lo_green), 1);

        do_reset();
        repeat (3) tick();
        C = 1'b1;
        tick();
        C = 1'b0;
        g = 0;
        repeat (30) begin
            g += int'(ns_green);
            tick();
        end
        chk("t4_hold", g, 30);

        do_reset();
        A = 1'b1;
        repeat (15) tick();
        C = 1'b1;
        len(0, n); chk("t5_rest_green", n, 5);
        chk("t5_yellow", int'(ns_yellow), 1);

        A = 1'b0;
        len(1, n); chk("t6_ns_yellow", n, 3);
        len(2, n); chk("t6_all_red", n, 1);
        C = 1'b0;
        A = 1'b1;
        len(3, n); chk("t6_lo_green", n, 8);
        chk("t6_lo_yellow", int'(lo_yellow), 1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_reds", int'({ns_red, lo_red}), 3);
        chk("t6_async_yel", int'(lo_yellow), 0);
        chk("t6_async_fase", int'(fase), 5);
        chk("t6_async_troca", int'(troca), 0);
        tick();
        reset_n = 1'b1;
        A = 1'b0;
        tick();
        chk("t6_ns_green", int'(ns_green), 1);
        chk("t6_troca", int'(troca), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
